// File: rtl/lsu_wb_if.sv
// ---------------------------------------------------------------------------
// lsu_wb_if : Wishbone B4 pipelined bus between the load/store unit (master)
//             and the data memory / interconnect (slave).
//
//   cyc, stb, we   master -> slave   bus cycle, strobe, write enable
//   adr            master -> slave   lane-aligned byte address (XLEN)
//   sel            master -> slave   byte enables (NB)
//   dat_w          master -> slave   write data, replicated across lanes
//   dat_r          slave  -> master  read data
//   ack, err       slave  -> master  cycle termination
//   stall          slave  -> master  strobe not accepted this cycle
// ---------------------------------------------------------------------------
interface lsu_wb_if #(
   parameter int XLEN = 32
);
   localparam int NB = XLEN / 8;

   logic            cyc;
   logic            stb;
   logic            we;
   logic [XLEN-1:0] adr;
   logic [NB-1:0]   sel;
   logic [XLEN-1:0] dat_w;
   logic [XLEN-1:0] dat_r;
   logic            ack;
   logic            err;
   logic            stall;

   modport master (
      output cyc, stb, we, adr, sel, dat_w,
      input  dat_r, ack, err, stall
   );

   modport slave (
      input  cyc, stb, we, adr, sel, dat_w,
      output dat_r, ack, err, stall
   );
endinterface

// File: rtl/lsu_wb.sv
// ---------------------------------------------------------------------------
// lsu_wb : pipelined load/store unit. Takes one request at a time from the
//          hart and runs it as a Wishbone B4 pipelined master cycle, with
//          byte-lane steering, sign/zero extension, misalignment detection,
//          bus error, bus timeout and pipeline kill.
//
//   clk, rst_n     clock, asynchronous active-low reset
//   i_req_valid    request present          o_req_ready  high only in IDLE
//   i_req_we       1 = store                i_req_ty     B/H/W/D/BU/HU/WU
//   i_req_addr     byte address             i_req_wdata  right-aligned data
//   i_kill         abort outstanding request / suppress its response
//   o_rsp_valid    one-cycle completion pulse
//   o_rsp_data     extended load data (0 for stores and errors)
//   o_rsp_err      00 ok, 01 misaligned/illegal, 10 bus error, 11 timeout
//   wb             Wishbone master port (lsu_wb_if.master)
// ---------------------------------------------------------------------------
module lsu_wb #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255,
   parameter int NB      = XLEN / 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_req_valid,
   output logic            o_req_ready,
   input  logic            i_req_we,
   input  logic [2:0]      i_req_ty,
   input  logic [XLEN-1:0] i_req_addr,
   input  logic [XLEN-1:0] i_req_wdata,
   input  logic            i_kill,
   output logic            o_rsp_valid,
   output logic [XLEN-1:0] o_rsp_data,
   output logic [1:0]      o_rsp_err,
   lsu_wb_if.master        wb
);
   localparam int          OW  = $clog2(NB);
   localparam logic [15:0] TMO = 16'(TIMEOUT);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_ERR} state_t;

   state_t            state;
   logic              ready_q;
   logic              rsp_valid_q;
   logic [XLEN-1:0]   rsp_data_q;
   logic [1:0]        rsp_err_q;
   logic              cyc_q, stb_q, we_q;
   logic [XLEN-1:0]   adr_q, dat_q;
   logic [NB-1:0]     sel_q;
   logic              st_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic [OW-1:0]     off_q;
   logic [15:0]       cnt;

   // request decode
   logic              accept;
   logic [1:0]        req_size;
   logic [OW-1:0]     req_off;
   logic              ty_ok, aligned;
   logic [NB-1:0]     sel_d;
   logic [XLEN-1:0]   wdat_d;

   // load path
   logic [XLEN-1:0]   ld_sh, keep, ld_ext;
   logic              fill;
   logic [15:0]       cnt_inc;

   assign accept   = i_req_valid && ready_q && !i_kill;
   assign req_size = i_req_ty[1:0];
   assign req_off  = i_req_addr[OW-1:0];
   assign cnt_inc  = cnt + 16'd1;

   always_comb begin
      ty_ok = 1'b0;
      case (i_req_ty)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ty_ok = 1'b1;
         3'b011, 3'b110:                         ty_ok = (XLEN == 64);
         default:                                ty_ok = 1'b0;
      endcase

      aligned = 1'b1;
      sel_d   = '1;
      wdat_d  = i_req_wdata;
      case (req_size)
         2'b00: begin
            sel_d  = NB'(1) << req_off;
            wdat_d = {NB{i_req_wdata[7:0]}};
         end
         2'b01: begin
            aligned = !i_req_addr[0];
            sel_d   = NB'(3) << req_off;
            wdat_d  = {(NB/2){i_req_wdata[15:0]}};
         end
         2'b10: begin
            aligned = (i_req_addr[1:0] == 2'b00);
            sel_d   = NB'(15) << req_off;
            wdat_d  = {(NB/4){i_req_wdata[31:0]}};
         end
         default: begin
            aligned = (i_req_addr[2:0] == 3'b000);
         end
      endcase
   end

   // Extension is done as a mask merge so the same logic covers every size
   // without zero-width replications when XLEN=32.
   always_comb begin
      ld_sh = wb.dat_r >> {off_q, 3'b000};
      case (size_q)
         2'b00:   begin keep = XLEN'(8'hFF);          fill = ld_sh[7];      end
         2'b01:   begin keep = XLEN'(16'hFFFF);       fill = ld_sh[15];     end
         2'b10:   begin keep = XLEN'(32'hFFFF_FFFF);  fill = ld_sh[31];     end
         default: begin keep = '1;                    fill = ld_sh[XLEN-1]; end
      endcase
      fill   = fill && !uns_q;
      ld_ext = (ld_sh & keep) | ({XLEN{fill}} & ~keep);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= '0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         sel_q       <= '0;
         st_q        <= 1'b0;
         size_q      <= '0;
         uns_q       <= 1'b0;
         off_q       <= '0;
         cnt         <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  ready_q <= 1'b0;
                  st_q    <= i_req_we;
                  size_q  <= req_size;
                  uns_q   <= i_req_ty[2];
                  off_q   <= req_off;
                  cnt     <= '0;
                  if (ty_ok && aligned) begin
                     state <= S_REQ;
                     cyc_q <= 1'b1;
                     stb_q <= 1'b1;
                     we_q  <= i_req_we;
                     adr_q <= i_req_addr & ~XLEN'(NB - 1);
                     sel_q <= sel_d;
                     dat_q <= wdat_d;
                  end else begin
                     state       <= S_ERR;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 2'b01;
                     rsp_data_q  <= '0;
                  end
               end
            end

            // REQ with stall=0 behaves like a WAIT cycle: the strobe is taken,
            // so ack/err/timeout are evaluated alongside dropping stb.
            S_REQ, S_WAIT: begin
               if (i_kill) begin
                  state   <= S_IDLE;
                  ready_q <= 1'b1;
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  we_q    <= 1'b0;
                  sel_q   <= '0;
               end else if (state == S_WAIT || !wb.stall) begin
                  if (wb.err || wb.ack || cnt_inc == TMO) begin
                     state       <= S_RESP;
                     rsp_valid_q <= 1'b1;
                     cyc_q       <= 1'b0;
                     stb_q       <= 1'b0;
                     we_q        <= 1'b0;
                     sel_q       <= '0;
                     if (wb.err) begin
                        rsp_err_q  <= 2'b10;
                        rsp_data_q <= '0;
                     end else if (wb.ack) begin
                        rsp_err_q  <= 2'b00;
                        rsp_data_q <= st_q ? '0 : ld_ext;
                     end else begin
                        rsp_err_q  <= 2'b11;
                        rsp_data_q <= '0;
                     end
                  end else begin
                     state <= S_WAIT;
                     stb_q <= 1'b0;
                     cnt   <= cnt_inc;
                  end
               end
            end

            default: begin
               state   <= S_IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign o_req_ready = ready_q;
   assign o_rsp_valid = rsp_valid_q && !i_kill;
   assign o_rsp_data  = rsp_data_q;
   assign o_rsp_err   = rsp_err_q;

   assign wb.cyc   = cyc_q;
   assign wb.stb   = stb_q;
   assign wb.we    = we_q;
   assign wb.adr   = adr_q;
   assign wb.sel   = sel_q;
   assign wb.dat_w = dat_q;
endmodule

// File: tb/tb_lsu_wb.sv
// ---------------------------------------------------------------------------
// tb_lsu_wb : directed bench for lsu_wb. One XLEN=32 and one XLEN=64 instance
//             (both TIMEOUT=4); the Wishbone slave side is driven step by step.
// ---------------------------------------------------------------------------
module tb_lsu_wb;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   n_chk  = 0;
   int   n_fail = 0;

   // XLEN=32 instance
   logic        v32, k32, we32, rdy32, rv32;
   logic [2:0]  ty32;
   logic [31:0] a32, wd32, rd32;
   logic [1:0]  re32;
   lsu_wb_if #(.XLEN(32)) wb32 ();

   lsu_wb #(.XLEN(32), .TIMEOUT(4)) u32 (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(v32), .o_req_ready(rdy32), .i_req_we(we32), .i_req_ty(ty32),
      .i_req_addr(a32), .i_req_wdata(wd32), .i_kill(k32),
      .o_rsp_valid(rv32), .o_rsp_data(rd32), .o_rsp_err(re32),
      .wb(wb32.master)
   );

   // XLEN=64 instance
   logic        v64, k64, we64, rdy64, rv64;
   logic [2:0]  ty64;
   logic [63:0] a64, wd64, rd64;
   logic [1:0]  re64;
   lsu_wb_if #(.XLEN(64)) wb64 ();

   lsu_wb #(.XLEN(64), .TIMEOUT(4)) u64 (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(v64), .o_req_ready(rdy64), .i_req_we(we64), .i_req_ty(ty64),
      .i_req_addr(a64), .i_req_wdata(wd64), .i_kill(k64),
      .o_rsp_valid(rv64), .o_rsp_data(rd64), .o_rsp_err(re64),
      .wb(wb64.master)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // presents a request for one cycle; returns in the cycle after acceptance
   task automatic issue32(input logic we, input logic [2:0] ty,
                          input logic [31:0] addr, input logic [31:0] wdata);
      v32 = 1'b1; we32 = we; ty32 = ty; a32 = addr; wd32 = wdata;
      tick();
      v32 = 1'b0;
   endtask

   task automatic issue64(input logic we, input logic [2:0] ty,
                          input logic [63:0] addr, input logic [63:0] wdata);
      v64 = 1'b1; we64 = we; ty64 = ty; a64 = addr; wd64 = wdata;
      tick();
      v64 = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      v32 = 0; k32 = 0; we32 = 0; ty32 = 0; a32 = 0; wd32 = 0;
      v64 = 0; k64 = 0; we64 = 0; ty64 = 0; a64 = 0; wd64 = 0;
      wb32.ack = 0; wb32.err = 0; wb32.stall = 0; wb32.dat_r = '0;
      wb64.ack = 0; wb64.err = 0; wb64.stall = 0; wb64.dat_r = '0;
      #12;
      // reset state
      chk("rst_ready", rdy32, 1);
      chk("rst_cyc", wb32.cyc, 0);
      chk("rst_stb", wb32.stb, 0);
      chk("rst_sel", wb32.sel, 0);
      chk("rst_rspv", rv32, 0);
      chk("rst_ready64", rdy64, 1);
      rst_n = 1'b1;
      tick();

      // LB 0x1003, zero-wait slave
      issue32(1'b0, 3'b000, 32'h0000_1003, 32'h0);
      chk("lb_cyc", wb32.cyc, 1);
      chk("lb_stb", wb32.stb, 1);
      chk("lb_sel", wb32.sel, 4'b1000);
      chk("lb_adr", wb32.adr, 32'h0000_1000);
      chk("lb_we", wb32.we, 0);
      chk("lb_ready", rdy32, 0);
      chk("lb_rspv_early", rv32, 0);
      wb32.ack = 1; wb32.dat_r = 32'h80AA_BBCC;
      tick();
      wb32.ack = 0;
      chk("lb_cyc_low", wb32.cyc, 0);
      chk("lb_rspv", rv32, 1);
      chk("lb_data", rd32, 32'hFFFF_FF80);
      chk("lb_err", re32, 2'b00);
      tick();
      chk("lb_rspv_pulse", rv32, 0);
      chk("lb_ready_back", rdy32, 1);

      // SH 0x2002, slave stalls 3 cycles
      wb32.stall = 1;
      issue32(1'b1, 3'b001, 32'h0000_2002, 32'h0000_1234);
      chk("sh_stb1", wb32.stb, 1);
      chk("sh_sel", wb32.sel, 4'b1100);
      chk("sh_dat", wb32.dat_w, 32'h1234_1234);
      chk("sh_we", wb32.we, 1);
      tick();
      chk("sh_stb2", wb32.stb, 1);
      tick();
      chk("sh_stb3", wb32.stb, 1);
      tick();
      wb32.stall = 0;
      chk("sh_stb4", wb32.stb, 1);
      tick();
      chk("sh_stb_drop", wb32.stb, 0);
      chk("sh_cyc_wait", wb32.cyc, 1);
      chk("sh_rspv_wait", rv32, 0);
      wb32.ack = 1;
      tick();
      wb32.ack = 0;
      chk("sh_rspv", rv32, 1);
      chk("sh_data", rd32, 0);
      chk("sh_err", re32, 2'b00);
      tick();

      // LW misaligned
      issue32(1'b0, 3'b010, 32'h0000_0001, 32'h0);
      chk("mis_cyc", wb32.cyc, 0);
      chk("mis_rspv", rv32, 1);
      chk("mis_err", re32, 2'b01);
      chk("mis_data", rd32, 0);
      tick();
      chk("mis_rspv_pulse", rv32, 0);
      chk("mis_ready", rdy32, 1);

      // D type illegal at XLEN=32
      issue32(1'b0, 3'b011, 32'h0000_0000, 32'h0);
      chk("ild_cyc", wb32.cyc, 0);
      chk("ild_rspv", rv32, 1);
      chk("ild_err", re32, 2'b01);
      tick();

      // kill during the error response suppresses it
      issue32(1'b0, 3'b001, 32'h0000_0003, 32'h0);
      k32 = 1;
      #1;
      chk("kerr_rspv", rv32, 0);
      tick();
      k32 = 0;
      chk("kerr_ready", rdy32, 1);

      // LHU, slave never acks, TIMEOUT=4
      issue32(1'b0, 3'b101, 32'h0000_0010, 32'h0);
      chk("to_stb", wb32.stb, 1);
      tick();
      chk("to_cyc2", wb32.cyc, 1);
      tick();
      tick();
      chk("to_cyc4", wb32.cyc, 1);
      chk("to_rspv4", rv32, 0);
      tick();
      chk("to_cyc_drop", wb32.cyc, 0);
      chk("to_rspv", rv32, 1);
      chk("to_err", re32, 2'b11);
      chk("to_data", rd32, 0);
      tick();
      chk("to_ready", rdy32, 1);

      // kill in IDLE blocks acceptance
      v32 = 1; k32 = 1; we32 = 0; ty32 = 3'b010; a32 = 32'h30;
      tick();
      v32 = 0; k32 = 0;
      chk("kidle_cyc", wb32.cyc, 0);
      chk("kidle_ready", rdy32, 1);

      // LW, kill in WAIT, late ack two cycles later
      issue32(1'b0, 3'b010, 32'h0000_0020, 32'h0);
      tick();
      chk("kw_cyc_wait", wb32.cyc, 1);
      k32 = 1;
      tick();
      k32 = 0;
      chk("kw_cyc", wb32.cyc, 0);
      chk("kw_stb", wb32.stb, 0);
      chk("kw_rspv", rv32, 0);
      chk("kw_ready", rdy32, 1);
      tick();
      wb32.ack = 1; wb32.dat_r = 32'hDEAD_BEEF;
      #1;
      chk("kw_late_rspv", rv32, 0);
      tick();
      wb32.ack = 0;
      chk("kw_late_rspv2", rv32, 0);
      chk("kw_late_cyc", wb32.cyc, 0);
      issue32(1'b0, 3'b010, 32'h0000_0024, 32'h0);
      chk("kw_next_stb", wb32.stb, 1);
      wb32.ack = 1; wb32.dat_r = 32'h1234_5678;
      tick();
      wb32.ack = 0;
      chk("kw_next_rspv", rv32, 1);
      chk("kw_next_data", rd32, 32'h1234_5678);
      tick();

      // SB lane steering, LH sign extension from upper half
      issue32(1'b1, 3'b000, 32'h0000_0041, 32'h0000_00AB);
      chk("sb_sel", wb32.sel, 4'b0010);
      chk("sb_dat", wb32.dat_w, 32'hABAB_ABAB);
      wb32.ack = 1;
      tick();
      wb32.ack = 0;
      tick();
      issue32(1'b0, 3'b001, 32'h0000_0042, 32'h0);
      chk("lh_sel", wb32.sel, 4'b1100);
      wb32.ack = 1; wb32.dat_r = 32'h9876_0000;
      tick();
      wb32.ack = 0;
      chk("lh_data", rd32, 32'hFFFF_9876);
      tick();

      // XLEN=64 LWU at offset 4
      issue64(1'b0, 3'b110, 64'h0000_0000_0000_0104, 64'h0);
      chk("lwu_sel", wb64.sel, 8'hF0);
      chk("lwu_adr", wb64.adr, 64'h0000_0000_0000_0100);
      wb64.ack = 1; wb64.dat_r = 64'h8000_0001_0000_0000;
      tick();
      wb64.ack = 0;
      chk("lwu_rspv", rv64, 1);
      chk("lwu_data", rd64, 64'h0000_0000_8000_0001);
      chk("lwu_err", re64, 2'b00);
      tick();

      // XLEN=64 LW signed, same data
      issue64(1'b0, 3'b010, 64'h0000_0000_0000_0204, 64'h0);
      wb64.ack = 1;
      tick();
      wb64.ack = 0;
      chk("lw64_data", rd64, 64'hFFFF_FFFF_8000_0001);
      tick();

      // XLEN=64 LD, ack and err together
      issue64(1'b0, 3'b011, 64'h0000_0000_0000_0108, 64'h0);
      chk("ld_sel", wb64.sel, 8'hFF);
      wb64.ack = 1; wb64.err = 1;
      tick();
      wb64.ack = 0; wb64.err = 0;
      chk("ae_rspv", rv64, 1);
      chk("ae_err", re64, 2'b10);
      chk("ae_data", rd64, 0);
      tick();

      // XLEN=64 SW replicated, LD misaligned
      issue64(1'b1, 3'b010, 64'h0000_0000_0000_0010, 64'h0000_0000_CAFE_F00D);
      chk("sw64_dat", wb64.dat_w, 64'hCAFE_F00D_CAFE_F00D);
      chk("sw64_sel", wb64.sel, 8'h0F);
      wb64.ack = 1;
      tick();
      wb64.ack = 0;
      tick();
      issue64(1'b0, 3'b011, 64'h0000_0000_0000_0004, 64'h0);
      chk("ldmis_err", re64, 2'b01);
      chk("ldmis_cyc", wb64.cyc, 0);
      tick();

      // asynchronous reset in the middle of a bus cycle
      wb32.stall = 1;
      issue32(1'b0, 3'b010, 32'h0000_0040, 32'h0);
      chk("ar_cyc_before", wb32.cyc, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_cyc", wb32.cyc, 0);
      chk("ar_stb", wb32.stb, 0);
      chk("ar_sel", wb32.sel, 0);
      chk("ar_ready", rdy32, 1);
      chk("ar_rspv", rv32, 0);
      rst_n = 1'b1;
      wb32.stall = 0;
      tick();
      chk("ar_cyc_after", wb32.cyc, 0);
      chk("ar_rspv_after", rv32, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
